rx_ctrl_fsm: RTL

RX_CTRL_FSM -- requirements
Module: rx_ctrl_fsm

---
 rtl/rx_ctrl_fsm.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/rx_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// rx_ctrl_fsm
//   Receive-side control FSM for an oversampled UART receiver. Detects the
//   falling edge of a start bit and tracks the position within the frame with
//   an edge counter (oversampling tick within a bit) and a bit counter.
//   It enables the start/parity/stop checkers and the deserializer on the last
//   tick of their bits. It then reports the frame as accepted (data_valid) or
//   rejected (frame_err) with a one-cycle pulse.
//
// Ports
//   CLK          in   rising-edge clock at the oversampling rate
//   RST          in   asynchronous active-low reset
//   RX_IN        in   serial line, idle high
//   PAR_EN       in   parity bit present (latched at frame start)
//   Prescale     in   oversampling ratio, 8/16/32 (latched at frame start)
//   strt_glitch  in   start-check result, 1 = glitch
//   par_err      in   parity-check result
//   stp_err      in   stop-check result
//   strt_chk_en  out  start-check enable (START bit-end cycle)
//   par_chk_en   out  parity-check enable (PARITY bit-end cycle)
//   stp_chk_en   out  stop-check enable (STOP bit-end cycle)
//   dat_samp_en  out  data-sampler enable (any non-IDLE state)
//   deser_en     out  deserializer shift enable (DATA bit-end cycle)
//   edge_cnt     out  edge position within the current bit
//   bit_cnt      out  bit index within the frame
//   data_valid   out  frame-accepted pulse
//   frame_err    out  frame-rejected pulse
// -----------------------------------------------------------------------------
module rx_ctrl_fsm (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic       PAR_EN,
  input  logic [5:0] Prescale,
  input  logic       strt_glitch,
  input  logic       par_err,
  input  logic       stp_err,
  output logic       strt_chk_en,
  output logic       par_chk_en,
  output logic       stp_chk_en,
  output logic       dat_samp_en,
  output logic       deser_en,
  output logic [5:0] edge_cnt,
  output logic [3:0] bit_cnt,
  output logic       data_valid,
  output logic       frame_err
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic [3:0] LAST_DATA_BIT = 4'd8;

  state_t     state_q;
  logic [5:0] edge_cnt_q;
  logic [3:0] bit_cnt_q;
  logic [5:0] pl_q;        // Prescale captured at frame start
  logic       par_en_q;    // PAR_EN captured at frame start
  logic       par_flag_q;  // parity error seen in the current frame
  logic       data_valid_q;
  logic       frame_err_q;

  logic       bit_end;

  // Last oversampling tick of the current bit. Out-of-range prescales still
  // wrap at pl_q-1 (pl_q=0 wraps at 63).
  assign bit_end = (edge_cnt_q == (pl_q - 6'd1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= ST_IDLE;
      edge_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      pl_q         <= '0;
      par_en_q     <= 1'b0;
      par_flag_q   <= 1'b0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      // Result pulses last one cycle unless re-armed below.
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;

      if (state_q == ST_IDLE) begin
        edge_cnt_q <= '0;
        bit_cnt_q  <= '0;
        if (!RX_IN) begin
          state_q    <= ST_START;
          pl_q       <= Prescale;
          par_en_q   <= PAR_EN;
          par_flag_q <= 1'b0;
        end
      end else begin
        // Common bit timing for all in-frame states; transitions back to
        // IDLE override the counters to zero below.
        if (bit_end) begin
          edge_cnt_q <= '0;
          bit_cnt_q  <= bit_cnt_q + 4'd1;
        end else begin
          edge_cnt_q <= edge_cnt_q + 6'd1;
        end

        case (state_q)
          ST_START: begin
            if (bit_end) begin
              if (strt_glitch) begin
                state_q    <= ST_IDLE;
                edge_cnt_q <= '0;
                bit_cnt_q  <= '0;
              end else begin
                state_q <= ST_DATA;
              end
            end
          end

          ST_DATA: begin
            if (bit_end && (bit_cnt_q == LAST_DATA_BIT)) begin
              state_q <= par_en_q ? ST_PARITY : ST_STOP;
            end
          end

          ST_PARITY: begin
            if (bit_end) begin
              par_flag_q <= par_err;
              state_q    <= ST_STOP;
            end
          end

          ST_STOP: begin
            if (bit_end) begin
              state_q    <= ST_IDLE;
              edge_cnt_q <= '0;
              bit_cnt_q  <= '0;
              if (stp_err || par_flag_q) begin
                frame_err_q <= 1'b1;
              end else begin
                data_valid_q <= 1'b1;
              end
            end
          end

          default: begin
            state_q    <= ST_IDLE;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
          end
        endcase
      end
    end
  end

  // Enables are pure decodes of the registered state and edge counter.
  always_comb begin
    strt_chk_en = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    deser_en    = 1'b0;
    dat_samp_en = (state_q != ST_IDLE);
    case (state_q)
      ST_START:  strt_chk_en = bit_end;
      ST_DATA:   deser_en    = bit_end;
      ST_PARITY: par_chk_en  = bit_end;
      ST_STOP:   stp_chk_en  = bit_end;
      default:   ;
    endcase
  end

  assign edge_cnt   = edge_cnt_q;
  assign bit_cnt    = bit_cnt_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;

endmodule
